// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// fixed latency of WIDTH+2 cycles from accepted start to the done pulse.
module muldiv_seq #(
   parameter int WIDTH    = 32,
   parameter int EARLY_DZ = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             dz,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_MLA   = 3'b001;
   localparam logic [2:0] OP_UMULL = 3'b100;
   localparam logic [2:0] OP_SMULL = 3'b110;
   localparam logic [2:0] OP_UDIV  = 3'b011;
   localparam logic [2:0] OP_SDIV  = 3'b111;

   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} stateT;

   stateT state, nextState;

   logic [CW-1:0]      cnt;
   logic [2:0]         opReg;
   logic [WIDTH-1:0]   opnd, hiReg, loReg, cReg;
   logic               signA, signB, dzPend;

   logic               legal, isDiv, isSigned, zeroDiv, accept, regIsDiv;
   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH:0]     mulSum, divShift, divDiff;
   logic               divFits;
   logic [2*WIDTH-1:0] prodNeg;
   logic [WIDTH-1:0]   quotNeg, remNeg, fixLo, fixHi;

   // Request decode
   always_comb begin
      legal    = (op == OP_MUL) || (op == OP_MLA) || (op == OP_UMULL) ||
                 (op == OP_SMULL) || (op == OP_UDIV) || (op == OP_SDIV);
      isDiv    = (op == OP_UDIV) || (op == OP_SDIV);
      isSigned = (op == OP_SMULL) || (op == OP_SDIV);
      magA     = (isSigned && a[WIDTH-1]) ? -a : a;
      magB     = (isSigned && b[WIDTH-1]) ? -b : b;
      zeroDiv  = isDiv && (b == '0);
      accept   = (state == IDLE) && start && !flush && legal;
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) nextState = (zeroDiv && EARLY_DZ != 0) ? FIX : ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (flush)                         nextState = IDLE;
            else if (cnt == CW'(WIDTH - 1))    nextState = FIX;
         end
         FIX: begin
            busy      = 1'b1;
            nextState = flush ? IDLE : DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // One iteration step; hiReg:loReg is the product shifter or remainder:quotient pair
   always_comb begin
      regIsDiv = (opReg == OP_UDIV) || (opReg == OP_SDIV);
      mulSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, opnd} : '0);
      divShift = {hiReg, loReg[WIDTH-1]};
      divDiff  = divShift - {1'b0, opnd};
      divFits  = divShift >= {1'b0, opnd};
      prodNeg  = -{hiReg, loReg};
      quotNeg  = -loReg;
      remNeg   = -hiReg;
   end

   // Sign correction and MLA addend applied on magnitude results
   always_comb begin
      fixLo = '0;
      fixHi = '0;
      case (opReg)
         OP_MUL:   fixLo = loReg;
         OP_MLA:   fixLo = loReg + cReg;
         OP_UMULL: begin
            fixHi = hiReg;
            fixLo = loReg;
         end
         OP_SMULL: begin
            if (signA ^ signB) {fixHi, fixLo} = prodNeg;
            else               {fixHi, fixLo} = {hiReg, loReg};
         end
         OP_UDIV: begin
            fixLo = loReg;
            fixHi = hiReg;
         end
         OP_SDIV: begin
            fixLo = (signA ^ signB) ? quotNeg : loReg;
            fixHi = signA ? remNeg : hiReg;
         end
         default: begin
            fixLo = '0;
            fixHi = '0;
         end
      endcase
      if (dzPend) begin
         fixLo = '0;
         fixHi = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt       <= '0;
         opReg     <= '0;
         opnd      <= '0;
         hiReg     <= '0;
         loReg     <= '0;
         cReg      <= '0;
         signA     <= 1'b0;
         signB     <= 1'b0;
         dzPend    <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         dz        <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         illegal <= (state == IDLE) && start && !flush && !legal;
         case (state)
            IDLE: begin
               if (accept) begin
                  opReg  <= op;
                  cReg   <= c;
                  signA  <= isSigned && a[WIDTH-1];
                  signB  <= isSigned && b[WIDTH-1];
                  dzPend <= zeroDiv;
                  cnt    <= '0;
                  hiReg  <= '0;
                  if (isDiv) begin
                     loReg <= magA;
                     opnd  <= magB;
                  end else begin
                     loReg <= magB;
                     opnd  <= magA;
                  end
               end
            end
            ITER: begin
               cnt <= cnt + 1'b1;
               if (regIsDiv) begin
                  hiReg <= divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
                  loReg <= {loReg[WIDTH-2:0], divFits};
               end else begin
                  {hiReg, loReg} <= {mulSum, loReg[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (!flush) begin
                  result_lo <= fixLo;
                  result_hi <= fixHi;
                  dz        <= dzPend;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: WIDTH=32 main instance plus a WIDTH=8 instance.
module tb_muldiv_seq;

   localparam logic [2:0] MUL = 3'b000, MLA = 3'b001, UMULL = 3'b100,
                          SMULL = 3'b110, UDIV = 3'b011, SDIV = 3'b111;

   logic        clk = 1'b0;
   logic        reset = 1'b0, start = 1'b0, flush = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0, c = '0;
   logic        busy, done, dz, illegal;
   logic [31:0] resultLo, resultHi;

   logic        reset8 = 1'b0, start8 = 1'b0, flush8 = 1'b0;
   logic [2:0]  op8 = '0;
   logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
   logic        busy8, done8, dz8, illegal8;
   logic [7:0]  resultLo8, resultHi8;

   int nTests = 0;
   int nFail  = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          due;
   } expT;
   expT sb[$];

   logic [31:0] lastLo = '0, lastHi = '0;

   muldiv_seq #(.WIDTH(32), .EARLY_DZ(1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .c(c),
      .flush(flush), .busy(busy), .done(done), .result_lo(resultLo),
      .result_hi(resultHi), .dz(dz), .illegal(illegal)
   );

   muldiv_seq #(.WIDTH(8), .EARLY_DZ(1)) dut8 (
      .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8), .c(c8),
      .flush(flush8), .busy(busy8), .done(done8), .result_lo(resultLo8),
      .result_hi(resultHi8), .dz(dz8), .illegal(illegal8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model(input logic [2:0] o, input logic [31:0] x, y, z,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic d);
      logic [63:0] p;
      longint      sx, sy, q, r;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      lo = '0; hi = '0; d = 1'b0;
      case (o)
         MUL:   lo = x * y;
         MLA:   lo = x * y + z;
         UMULL: begin p = {32'b0, x} * {32'b0, y}; {hi, lo} = p; end
         SMULL: begin q = sx * sy; p = q; {hi, lo} = p; end
         UDIV:  if (y == 0) d = 1'b1; else begin lo = x / y; hi = x % y; end
         SDIV:  if (y == 0) d = 1'b1;
                else begin q = sx / sy; r = sx % sy; lo = q[31:0]; hi = r[31:0]; end
         default: ;
      endcase
   endfunction

   // Compare every done pulse against the oldest outstanding expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) checkEq("spuriousDone", 64'(done), 64'd0);
         else begin
            expT e;
            e = sb.pop_front();
            checkEq("resultLo", 64'(resultLo), 64'(e.lo));
            checkEq("resultHi", 64'(resultHi), 64'(e.hi));
            checkEq("dz", 64'(dz), 64'(e.dz));
            checkEq("doneCycle", 64'(cyc), 64'(e.due));
         end
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge it is idle again
   task automatic runOp(input logic [2:0] o, input logic [31:0] x, y, z, input int restartAt);
      logic [31:0] lo, hi;
      logic        d;
      int          lat, busyCnt;
      expT         e;
      model(o, x, y, z, lo, hi, d);
      lat = d ? 2 : 34;
      op = o; a = x; b = y; c = z; start = 1'b1;
      e.lo = lo; e.hi = hi; e.dz = d; e.due = cyc + lat;
      sb.push_back(e);
      @(negedge clk);
      busyCnt = 0;
      for (int i = 1; i <= 100; i++) begin
         if (busy !== 1'b1) break;
         busyCnt++;
         start = (i == restartAt);
         if (start) begin op = MUL; a = 32'h1234; b = 32'h5678; end
         @(negedge clk);
      end
      start = 1'b0;
      checkEq("busyLen", 64'(busyCnt), 64'(lat));
      lastLo = lo;
      lastHi = hi;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0] ops [6];
      int         c0, doneAt;
      ops = '{MUL, MLA, UMULL, SMULL, UDIV, SDIV};

      repeat (3) @(negedge clk);
      checkEq("rstBusy", 64'(busy), 64'd0);
      checkEq("rstDone", 64'(done), 64'd0);
      checkEq("rstIllegal", 64'(illegal), 64'd0);
      checkEq("rstDz", 64'(dz), 64'd0);
      checkEq("rstLo", 64'(resultLo), 64'd0);
      checkEq("rstHi", 64'(resultHi), 64'd0);

      // Start in the very cycle reset deasserts
      reset = 1'b1;
      runOp(UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0);
      checkEq("umullHi", 64'(resultHi), 64'hFFFFFFFE);
      checkEq("umullLo", 64'(resultLo), 64'h00000001);
      runOp(SMULL, 32'hFFFFFFFE, 32'd3, 32'h0, 0);
      checkEq("smullHi", 64'(resultHi), 64'hFFFFFFFF);
      checkEq("smullLo", 64'(resultLo), 64'hFFFFFFFA);
      runOp(MLA, 32'd7, 32'd6, 32'd5, 0);
      checkEq("mlaLo", 64'(resultLo), 64'd47);
      runOp(SDIV, 32'hFFFFFFF9, 32'd2, 32'h0, 0);
      checkEq("sdivLo", 64'(resultLo), 64'hFFFFFFFD);
      checkEq("sdivHi", 64'(resultHi), 64'hFFFFFFFF);
      runOp(SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0);
      checkEq("sdivMinLo", 64'(resultLo), 64'h80000000);
      runOp(UDIV, 32'd100, 32'd0, 32'h0, 0);
      runOp(MLA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

      // Second start mid-operation must be ignored
      runOp(UDIV, 32'd10, 32'd3, 32'h0, 5);

      // Illegal op: one-cycle pulse, stays idle, results untouched
      op = 3'b010; a = 32'd9; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkEq("illegalPulse", 64'(illegal), 64'd1);
      checkEq("illegalIdle", 64'(busy), 64'd0);
      @(negedge clk);
      checkEq("illegalOnce", 64'(illegal), 64'd0);
      checkEq("illegalHoldLo", 64'(resultLo), 64'(lastLo));

      // Flush in cycle 10 of a divide
      op = UDIV; a = 32'd10; b = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkEq("flushIdle", 64'(busy), 64'd0);
      checkEq("flushHoldLo", 64'(resultLo), 64'(lastLo));
      checkEq("flushHoldHi", 64'(resultHi), 64'(lastHi));
      repeat (40) @(negedge clk);

      // Flush and start together in idle: start dropped
      op = MUL; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checkEq("flushStartIdle", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);

      for (int i = 0; i < 24; i++)
         runOp(ops[$urandom_range(0, 5)], pick(), pick(), pick(), 0);

      // Reset in cycle 4 of an operation, with start also held high
      op = UMULL; a = 32'd5; b = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0; start = 1'b1;
      @(negedge clk);
      checkEq("midRstBusy", 64'(busy), 64'd0);
      checkEq("midRstLo", 64'(resultLo), 64'd0);
      checkEq("midRstHi", 64'(resultHi), 64'd0);
      checkEq("midRstDz", 64'(dz), 64'd0);
      reset = 1'b1;
      runOp(SDIV, 32'hFFFFFF9C, 32'd7, 32'h0, 0);

      // WIDTH=8 instance
      reset8 = 1'b1; op8 = UMULL; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      c0 = cyc; doneAt = -1;
      @(negedge clk);
      start8 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done8 === 1'b1) begin doneAt = cyc - c0; break; end
         @(negedge clk);
      end
      checkEq("w8DoneCycle", 64'(doneAt), 64'd10);
      checkEq("w8Hi", 64'(resultHi8), 64'hFE);
      checkEq("w8Lo", 64'(resultLo8), 64'h01);
      @(negedge clk);
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      reset8 = 1'b0;
      @(negedge clk);
      checkEq("w8RstBusy", 64'(busy8), 64'd0);
      checkEq("w8RstDone", 64'(done8), 64'd0);
      checkEq("w8RstIllegal", 64'(illegal8), 64'd0);
      checkEq("w8RstDz", 64'(dz8), 64'd0);
      checkEq("w8RstLo", 64'(resultLo8), 64'd0);
      checkEq("w8RstHi", 64'(resultHi8), 64'd0);

      repeat (4) @(negedge clk);
      checkEq("scoreboardEmpty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
